// File: rtl/program_loader.sv
// Serial program loader: receives framed instruction words from a byte
// stream, writes them into instruction memory and holds the CPU in clear
// until a frame with a good checksum has been loaded.
module program_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [31:0] TIMEOUT   = 32'd100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_write,
    output logic [7:0]  prog_addr,
    output logic [31:0] prog_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TMO_W  = 32;
    localparam int unsigned BIDX_W = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   count_q, count_d;
    logic [BYTE_W-1:0]   word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [BYTE_W-1:0]   checksum_q, checksum_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rx_ready_d, prog_write_d, cpu_hold_d, done_d, error_d;
    logic [BYTE_W-1:0]   prog_addr_d;
    logic [WORD_W-1:0]   prog_data_d;
    logic                accept_c;
    logic                timeout_c;
    logic                is_sync_c;
    logic [WORD_W-1:0]   shifted_c;

    assign accept_c  = rx_valid & rx_ready;
    assign timeout_c = (tmo_q >= TIMEOUT);
    assign is_sync_c = (rx_data == SYNC_BYTE);
    assign shifted_c = {shreg_q[WORD_W-BYTE_W-1:0], rx_data};

    // State and datapath registers; reset forces the idle, CPU-released state
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            checksum_q <= '0;
            shreg_q    <= '0;
            tmo_q      <= '0;
            rx_ready   <= 1'b1;
            prog_write <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            checksum_q <= checksum_d;
            shreg_q    <= shreg_d;
            tmo_q      <= tmo_d;
            rx_ready   <= rx_ready_d;
            prog_write <= prog_write_d;
            prog_addr  <= prog_addr_d;
            prog_data  <= prog_data_d;
            cpu_hold   <= cpu_hold_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    // Next-state decode; an expired timeout wins over a byte arriving the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept_c && is_sync_c) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (timeout_c)     state_d = S_ERR;
                else if (accept_c) state_d = S_DATA;
            end
            S_DATA: begin
                if (timeout_c)                                state_d = S_ERR;
                else if (accept_c && byte_idx_q == BIDX_W'(3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = (word_idx_q == count_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (timeout_c)     state_d = S_ERR;
                else if (accept_c) state_d = (rx_data == checksum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for datapath and registered outputs
    always_comb begin
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        checksum_d   = checksum_q;
        shreg_d      = shreg_q;
        tmo_d        = '0;
        prog_write_d = 1'b0;
        prog_addr_d  = prog_addr;
        prog_data_d  = prog_data;
        cpu_hold_d   = cpu_hold;
        done_d       = done;
        error_d      = error;
        rx_ready_d   = (state_d != S_WRITE);

        // Inter-byte watchdog only runs while a frame is being received
        if (state_q == S_COUNT || state_q == S_DATA || state_q == S_CHECK) begin
            tmo_d = accept_c ? '0 : tmo_q + TMO_W'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept_c && is_sync_c) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    checksum_d = '0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_COUNT: begin
                if (accept_c) begin
                    count_d    = rx_data;
                    checksum_d = rx_data;
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    shreg_d    = shifted_c;
                    checksum_d = checksum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + BIDX_W'(1);
                end
            end
            S_WRITE: begin
                if (word_idx_q != count_q) word_idx_d = word_idx_q + BYTE_W'(1);
            end
            default: ;
        endcase

        // Strobe is registered, so it is raised on the edge that enters WRITE
        if (state_d == S_WRITE && state_q != S_WRITE) begin
            prog_write_d = 1'b1;
            prog_addr_d  = word_idx_q;
            prog_data_d  = shifted_c;
        end

        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
        end

        if (state_d == S_ERR && state_q != S_ERR) begin
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
        end
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: SYNC_BYTE, 8'hA5, start-of-frame marker.
REQ-002 Parameter: TIMEOUT, 32'd100000, maximum clk cycles allowed between accepted bytes inside a frame.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: clr  input  1  reset; asynchronous, active-low.
REQ-005 Port: rx_data  input  8  incoming byte from serial receiver.
REQ-006 Port: rx_valid  input  1  rx_data holds a valid byte.
REQ-007 Port: rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port: prog_write  output  1  instruction-memory write strobe.
REQ-009 Port: prog_addr  output  8  instruction-memory word address.
REQ-010 Port: prog_data  output  32  instruction word to write.
REQ-011 Port: cpu_hold  output  1  holds the processor in clear while high.
REQ-012 Port: done  output  1  last frame loaded with good checksum.
REQ-013 Port: error  output  1  last frame aborted (bad checksum or timeout).

Function
REQ-014 A byte is accepted on a rising clk edge where rx_valid and rx_ready are both 1; no other byte has any effect.
REQ-015 Frame format: SYNC_BYTE, count byte C, then 4*(C+1) data bytes (MSB first per word), then checksum byte; C=0 means 1 word, C=255 means 256 words.
REQ-016 States: IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR.
REQ-017 IDLE/DONE/ERR: rx_ready=1; accepted byte equal to SYNC_BYTE -> COUNT, clears done, error, word index, byte index, checksum, and sets cpu_hold=1; any other byte is discarded.
REQ-018 COUNT: rx_ready=1; accepted byte stored as C, checksum := byte -> DATA.
REQ-019 DATA: rx_ready=1; each accepted byte shifts into a 32-bit assembly register (first byte ends in [31:24]) and XORs into checksum; on the 4th byte -> WRITE.
REQ-020 WRITE: exactly one cycle; rx_ready=0, prog_write=1, prog_addr=word index, prog_data=assembled word.
REQ-021 Leaving WRITE: if word index == C -> CHECK; else word index increments by 1 and returns to DATA.
REQ-022 CHECK: rx_ready=1; accepted byte equal to checksum -> DONE, else -> ERR.
REQ-023 DONE: done=1, cpu_hold=0. ERR: error=1, cpu_hold=1 (processor not released on a bad load).
REQ-024 prog_write is 0 in every state except WRITE; prog_addr/prog_data hold their last values otherwise.
REQ-025 Timeout counter resets to 0 on every accepted byte and on entry to COUNT; in COUNT, DATA or CHECK it increments each cycle without an accepted byte; reaching TIMEOUT -> ERR next edge.
REQ-026 Timeout counter does not run in IDLE, WRITE, DONE or ERR.
REQ-027 Word index is 8 bits; 256-word frame ends at index 255 via REQ-021 comparison, no wrap write to address 0.
REQ-028 A SYNC_BYTE value received inside COUNT/DATA/CHECK is treated as ordinary data (no resync).
REQ-029 Outputs are registered; no combinational path from rx_data/rx_valid to any output except none (rx_ready depends on state only).

Reset
REQ-030 clr=0 asynchronously forces IDLE; rx_ready=1, prog_write=0, prog_addr=0, prog_data=0, cpu_hold=0, done=0, error=0, all counters and checksum 0.
REQ-031 Reset mid-frame abandons the frame; words already written remain in memory; no further prog_write until a new frame.

Verification
REQ-032 Frame A5,00,12,34,56,78,checksum 00^12^34^56^78=08 -> one prog_write with addr 0, data 32'h12345678; done=1, cpu_hold=0.
REQ-033 Frame A5,01, words 32'h00000001 and 32'hFFFFFFFF, correct checksum -> writes addr 0 then addr 1, each strobe 1 cycle, rx_ready=0 during each strobe.
REQ-034 Same frame as REQ-032 with checksum 09 -> write to addr 0 occurs, then error=1, done=0, cpu_hold=1.
REQ-035 TIMEOUT=10: A5,00,12 then rx_valid=0 for 10 cycles -> error=1, no prog_write; next A5 clears error and restarts.
REQ-036 C=FF frame of 256 words, rx_valid held 1 -> 256 strobes, addresses 0..255 in order, done=1.
REQ-037 clr pulsed low after 2nd data byte of a frame -> all outputs at reset values immediately; following valid frame loads correctly.
